muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32M MUL/DIV/REM family, sitting beside the EX-stage ALU.

---
 rtl/muldiv_ctrl_pkg.sv | 31 +++
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_ctrl.sv | 137 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op codes follow funct3 so decode can pass the field through unchanged.
package muldiv_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's complement negate when requested; used for magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic            start_i;
  logic            flush_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, op_i, a_i, b_i,
    input  busy_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, op_i, a_i, b_i,
    output busy_o, stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// trial-subtract/shift for divide, both on a 2*XLEN accumulator {hi, lo}.
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, opb};
    acc_next = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      // A clear MSB means the trial subtraction did not borrow.
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
      else             acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M MUL/DIV/REM sequencer beside the EX-stage ALU: stalls the
// pipeline, iterates one bit per cycle, then pulses done with the result.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  muldiv_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  md_op_e            op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   result_q;
  logic              neg_quo_q, neg_rem_q;
  logic              busy, stall, done;

  // Issue-time decode.
  md_op_e op_in;
  logic   is_div_in, a_signed, b_signed, a_neg, b_neg;
  logic   div_zero, div_ovf, special, launch;

  assign op_in     = md_op_e'(bus.op_i);
  assign is_div_in = op_in inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  assign a_signed  = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  assign b_signed  = op_in inside {MD_MULH, MD_DIV, MD_REM};
  assign a_neg     = a_signed & bus.a_i[XLEN-1];
  assign b_neg     = b_signed & bus.b_i[XLEN-1];
  assign div_zero  = is_div_in && (bus.b_i == '0);
  assign div_ovf   = (op_in inside {MD_DIV, MD_REM}) &&
                     (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
  assign special   = div_zero | div_ovf;
  assign launch    = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;

  muldiv_step u_step (
    .is_div   (op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}),
    .acc      (acc_q),
    .opb      (opb_q),
    .acc_next (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Special cases preload their answer and pass through FIX, so done still
  // lands one edge after issue without a separate result path.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start_i) state_d = special ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q == ST_CALC) || (state_q == ST_FIX);
    stall = busy || (bus.start_i && (state_q == ST_IDLE) && !bus.flush_i);
    done  = (state_q == ST_DONE);
  end

  // Sign fix-up and output select.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    prod       = neg_quo_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    fix_result = '0;
    unique case (op_q)
      MD_MUL:                       fix_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_result = neg_if(acc_q[XLEN-1:0], neg_quo_q);
      MD_REM, MD_REMU:              fix_result = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
      default:                      fix_result = '0;
    endcase
  end

  // NOTE: the datapath registers are plain flops, not a memory array, so
  // they take the async reset like the FSM and never start as X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q      <= MD_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (launch) begin
        op_q  <= op_in;
        cnt_q <= '0;
        opb_q <= neg_if(bus.b_i, b_neg);
        if (div_zero) begin
          acc_q     <= {bus.a_i, {XLEN{1'b1}}};
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (div_ovf) begin
          acc_q     <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          acc_q     <= {{XLEN{1'b0}}, neg_if(bus.a_i, a_neg)};
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
        end
      end else if ((state_q == ST_CALC) && !bus.flush_i) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_FIX) && !bus.flush_i) result_q <= fix_result;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.stall_o  = stall;
  assign bus.done_o   = done;
  assign bus.result_o = result_q;

  // The pipeline is frozen while busy, so a new issue here is a protocol error.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!rstn) busy |-> !bus.start_i
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed vectors, latency and stall
// profile, flush/reset aborts, plus a short sweep against a native-arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_res(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb);            return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bit is_div = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    bit ovf    = (op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return (is_div && (b == 0 || ovf)) ? 1 : 33;
  endfunction

  // Issue one op, then sample #1 after each edge until done (bounded).
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat, stall_n;
    bit seen;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    #1 check({tag, " stall_at_issue"}, 32'(bus.stall_o), 32'd1);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    lat = 100; stall_n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      if (bus.stall_o) stall_n++;
      @(posedge clk);
      #1;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.result_o, exp_res);
    check({tag, " stall_cycles"}, 32'(stall_n), 32'(exp_lat));
    check({tag, " stall_at_done"}, 32'(bus.stall_o), 32'd0);
    if (seen) begin
      @(posedge clk);
      #1 check({tag, " done_width"}, 32'(bus.done_o), 32'd0);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (bus.done_o) n++;
    end
  endtask

  initial begin
    int n_done;
    md_op_e op;
    logic [31:0] a, b;

    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.a_i     = '0;
    bus.b_i     = '0;

    #2;
    check("reset busy",   32'(bus.busy_o),  32'd0);
    check("reset done",   32'(bus.done_o),  32'd0);
    check("reset stall",  32'(bus.stall_o), 32'd0);
    check("reset result", bus.result_o,     32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Multiply family.
    run_op("mul 7*-3",       MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu max*max",  MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh min*2",     MD_MULH,   32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("mulhsu -1*umax", MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Divide family.
    run_op("div -20/3",  MD_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem -20%3",  MD_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("divu 100/7", MD_DIVU, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu 100%7", MD_REMU, 32'd100,       32'd7, 32'd2,         33);

    // Special cases finish one edge after issue.
    run_op("divu 5/0",    MD_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem 5%0",     MD_REM,  32'd5,         32'd0,         32'd5,         1);
    run_op("div ovf",     MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",     MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    run_op("div -7/0",    MD_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);

    // Flush mid-multiply: no done, previous result (0xFFFF_FFFF) kept.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = MD_MUL; bus.a_i = 32'd3; bus.b_i = 32'd4;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    check("flush busy", 32'(bus.busy_o), 32'd0);
    count_done(40, n_done);
    check("flush no_done", 32'(n_done), 32'd0);
    check("flush result_hold", bus.result_o, 32'hFFFF_FFFF);

    // Flush and start together: nothing issues.
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = MD_DIVU; bus.a_i = 32'd9; bus.b_i = 32'd3;
    #1 check("flush+start stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1 bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("flush+start busy", 32'(bus.busy_o), 32'd0);
    count_done(40, n_done);
    check("flush+start no_done", 32'(n_done), 32'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = MD_DIV; bus.a_i = 32'hFFFF_FFEC; bus.b_i = 32'd3;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (19) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midreset busy",   32'(bus.busy_o),  32'd0);
    check("midreset done",   32'(bus.done_o),  32'd0);
    check("midreset stall",  32'(bus.stall_o), 32'd0);
    check("midreset result", bus.result_o,     32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op("divu 9/3 after reset", MD_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Short sweep biased toward corner operands.
    for (int k = 0; k < 200; k++) begin
      op = md_op_e'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("sweep%0d op%0d", k, op), op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
